// File: rtl/seq_det_fsm.sv
// Serial "010110" pattern detector (Moore, overlapping matches, registered one-cycle flag).
// Optional saturating detection counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det_fsm #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_in,
    output logic               serial_out
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [COUNT_W-1:0] det_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S0     = 3'd1,
        S01    = 3'd2,
        S010   = 3'd3,
        S0101  = 3'd4,
        S01011 = 3'd5,
        DET    = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    if (COUNT_W == 0) begin : g_bad_count_w
        $error("seq_det_fsm: COUNT_W must be at least 1");
    end

    // Longest-suffix transitions; DET reuses its trailing 0 as the start of the next match.
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = bit_in ? IDLE   : S0;
            S0:      nxt = bit_in ? S01    : S0;
            S01:     nxt = bit_in ? IDLE   : S010;
            S010:    nxt = bit_in ? S0101  : S0;
            S0101:   nxt = bit_in ? S01011 : S010;
            S01011:  nxt = bit_in ? IDLE   : DET;
            DET:     nxt = bit_in ? S01    : S0;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    assign state_nxt = next_state(state, serial_in);

    // serial_out is registered alongside the state, so it always equals (state == DET).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            serial_out <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
            det_count  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            serial_out <= (state_nxt == DET);
`ifdef SEQ_DET_COUNT_EN
            if ((state_nxt == DET) && (det_count != '1)) begin
                det_count <= det_count + COUNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_det_fsm.sv
// Directed self-checking bench for seq_det_fsm; det_count checks compile in with SEQ_DET_COUNT_EN.
module tb_seq_det_fsm;

    localparam int unsigned COUNT_W = 8;

    logic               clk;
    logic               rst;
    logic               serial_in;
    logic               serial_out;
`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] det_count;
`endif

    int unsigned n_checks;
    int unsigned n_fail;

    seq_det_fsm #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .serial_out (serial_out)
`ifdef SEQ_DET_COUNT_EN
        ,
        .det_count  (det_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit at the falling edge, return 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        serial_in = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (serial_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: serial_out=%b expected 0", i, serial_out);
            end
`ifdef SEQ_DET_COUNT_EN
            n_checks++;
            if (det_count !== '0) begin
                n_fail++;
                $display("FAIL reset_count: det_count=%0d expected 0", det_count);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: serial_out=%b expected 0", serial_out);
        end
    endtask

    task automatic test_single();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b0101101;
        exp  = 7'b0000010;
        apply_reset();
        for (int i = 6; i >= 0; i--) begin
            send_bit(bits[i]);
            n_checks++;
            if (serial_out !== exp[i]) begin
                n_fail++;
                $display("FAIL single bit %0d: serial_out=%b expected %b", 7 - i, serial_out, exp[i]);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        n_checks++;
        if (det_count !== COUNT_W'(1)) begin
            n_fail++;
            $display("FAIL single_count: det_count=%0d expected 1", det_count);
        end
`endif
    endtask

    task automatic test_no_match();
        logic [5:0] bits;
        bits = 6'b010010;
        apply_reset();
        for (int i = 5; i >= 0; i--) begin
            send_bit(bits[i]);
            n_checks++;
            if (serial_out !== 1'b0) begin
                n_fail++;
                $display("FAIL no_match bit %0d: serial_out=%b expected 0", 6 - i, serial_out);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        n_checks++;
        if (det_count !== '0) begin
            n_fail++;
            $display("FAIL no_match_count: det_count=%0d expected 0", det_count);
        end
`endif
    endtask

    task automatic test_stream();
        logic [23:0] bits;
        logic [23:0] exp;
        bits = 24'b010110_010010_010110_010110;
        exp  = 24'b000001_000000_000001_000001;
        apply_reset();
        for (int i = 23; i >= 0; i--) begin
            send_bit(bits[i]);
            n_checks++;
            if (serial_out !== exp[i]) begin
                n_fail++;
                $display("FAIL stream bit %0d: serial_out=%b expected %b", 24 - i, serial_out, exp[i]);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        n_checks++;
        if (det_count !== COUNT_W'(3)) begin
            n_fail++;
            $display("FAIL stream_count: det_count=%0d expected 3", det_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        logic [10:0] exp;
        bits = 11'b010110_10110;
        exp  = 11'b000001_00001;
        apply_reset();
        for (int i = 10; i >= 0; i--) begin
            send_bit(bits[i]);
            n_checks++;
            if (serial_out !== exp[i]) begin
                n_fail++;
                $display("FAIL overlap bit %0d: serial_out=%b expected %b", 11 - i, serial_out, exp[i]);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        n_checks++;
        if (det_count !== COUNT_W'(2)) begin
            n_fail++;
            $display("FAIL overlap_count: det_count=%0d expected 2", det_count);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [3:0] pre;
        logic [7:0] post;
        logic [7:0] exp;
        pre  = 4'b0101;
        post = 8'b10_010110;
        exp  = 8'b00_000001;
        apply_reset();
        for (int i = 3; i >= 0; i--) begin
            send_bit(pre[i]);
        end
        // Assert reset away from any clock edge to observe the asynchronous clear.
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: serial_out=%b expected 0", serial_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(post[i]);
            n_checks++;
            if (serial_out !== exp[i]) begin
                n_fail++;
                $display("FAIL mid_reset bit %0d: serial_out=%b expected %b", 8 - i, serial_out, exp[i]);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        n_checks++;
        if (det_count !== COUNT_W'(1)) begin
            n_fail++;
            $display("FAIL mid_reset_count: det_count=%0d expected 1", det_count);
        end
`endif
    endtask

`ifdef SEQ_DET_COUNT_EN
    task automatic test_count_saturate();
        logic [5:0] first;
        logic [4:0] tail;
        first = 6'b010110;
        tail  = 5'b10110;
        apply_reset();
        for (int i = 5; i >= 0; i--) send_bit(first[i]);
        for (int d = 1; d < 300; d++) begin
            for (int i = 4; i >= 0; i--) send_bit(tail[i]);
            if (d == 254) begin
                n_checks++;
                if (det_count !== '1) begin
                    n_fail++;
                    $display("FAIL count_at_max: det_count=%0d expected 255", det_count);
                end
            end
        end
        n_checks++;
        if (det_count !== '1) begin
            n_fail++;
            $display("FAIL count_saturate: det_count=%0d expected 255", det_count);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        serial_in = 1'b0;
        test_reset();
        test_single();
        test_no_match();
        test_stream();
        test_back_to_back();
        test_mid_reset();
`ifdef SEQ_DET_COUNT_EN
        test_count_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_det_fsm.md
Name: seq_det_fsm

Overview:
- Serial bit-stream pattern detector: Moore FSM that flags each occurrence of the 6-bit sequence 0,1,0,1,1,0 (first bit received first) on a 1-bit serial input.
- Overlapping occurrences are detected.
- Sits at the edge of a serial receive path, one bit sampled per clock. Its single-cycle flag feeds downstream control logic.

Parameters:
- COUNT_W, 8, width of the optional detection counter. Unused unless SEQ_DET_COUNT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low. 0 forces reset immediately; release is synchronous to clk.
- serial_in  input  1  serial data bit, sampled on every rising clk edge.
- serial_out  output  1  detection flag. Registered Moore output; high for exactly one cycle per detected pattern.
- det_count  output  COUNT_W  number of detections. Present only when SEQ_DET_COUNT_EN is defined.

Behaviour:
- One bit is consumed per rising clk edge. There is no enable and no handshake.
- States, one-hot or binary encoding at implementer's choice, 7 total:
  - IDLE: no prefix matched
  - S0: "0"
  - S01: "01"
  - S010: "010"
  - S0101: "0101"
  - S01011: "01011"
  - DET: full "010110" matched
- Transitions, written as in=0 / in=1:
  - IDLE -> S0 / IDLE
  - S0 -> S0 / S01
  - S01 -> S010 / IDLE
  - S010 -> S0 / S0101
  - S0101 -> S010 / S01011
  - S01011 -> DET / IDLE
  - DET -> S0 / S01 (the trailing 0 of a match is reused as the first bit of the next match)
- serial_out = 1 iff the state is DET. It is decoded from the state register only, with no combinational path from serial_in.
- Latency: serial_out rises on the same clk edge that samples the final 0 and stays high for that one clock period.
- Back-to-back patterns:
  - "010110" followed immediately by "10110" gives a second detection 5 cycles after the first.
  - Minimum spacing between detections is 5 cycles.
- Reset:
  - rst=0 at any time, including mid-pattern, forces state IDLE and serial_out=0 asynchronously.
  - A partial match is discarded.
  - After release, a full 6 new bits are needed for a detection.
- X on serial_in is not required to be handled. serial_in must be driven from the first sampling edge after reset release.
- Unreachable state encodings recover to IDLE on the next clock.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - Adds output det_count (COUNT_W bits).
  - Reset value is 0.
  - Increments by 1 on each clock edge that enters DET.
  - Saturates at all-ones; no wrap.
  - Cleared asynchronously by rst=0.
- Not defined:
  - det_count port and its logic are absent.
  - Detection behaviour is identical in both builds.

Test Plan:
- Hold rst=0 for 2 cycles, then release -> serial_out=0 during and after reset. det_count=0 if enabled.
- Drive 0,1,0,1,1,0, one bit per cycle -> serial_out=1 for exactly the cycle after the 6th sample edge; 0 otherwise.
- Drive 0,1,0,0,1,0 -> serial_out stays 0 throughout.
- Drive the 24-bit stream 010110 010010 010110 010110 -> exactly 3 single-cycle pulses, at bit positions 6, 18 and 24. det_count=3 if enabled.
- Drive 0,1,0,1,1,0,1,0,1,1,0 (overlap) -> 2 pulses, 5 cycles apart.
- Drive 0,1,0,1, assert rst=0 mid-pattern, release, then drive 1,0 -> no pulse. Then drive a full 010110 -> 1 pulse.
